// File: rtl/lcd_pkg.sv
// Shared definitions for the ST7789 LCD path: command opcodes, SPI word layout,
// fill-engine state encoding and panel geometry defaults.
package lcd_pkg;

  localparam int WORD_W = 9;
  localparam int DC_BIT = 8;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  localparam int DEF_WIDTH  = 240;
  localparam int DEF_HEIGHT = 135;
  localparam int DEF_X_OFF  = 40;
  localparam int DEF_Y_OFF  = 53;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CASET,
    S_CP0,
    S_CP1,
    S_CP2,
    S_CP3,
    S_RASET,
    S_RP0,
    S_RP1,
    S_RP2,
    S_RP3,
    S_RAMWR,
    S_PIX_HI,
    S_PIX_LO
  } lcd_state_t;

  function automatic logic [WORD_W-1:0] lcd_word(input logic dc, input logic [7:0] b);
    logic [WORD_W-1:0] w;
    w         = '0;
    w[DC_BIT] = dc;
    w[7:0]    = b;
    return w;
  endfunction

endpackage

// File: rtl/lcd_stream_reg.sv
// Valid/ready output holding register: once a word is presented it stays
// unchanged until the downstream stage takes it.
module lcd_stream_reg
  import lcd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  input  logic              out_ready
);

  // Handshake: a word moves on a clk edge where out_valid && out_ready; while
  // out_valid is high and out_ready low, out_valid and out_data hold.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      out_data  <= in_valid ? in_data : '0;
    end
  end

endmodule

// File: rtl/lcd_fill_engine.sv
// Rectangle fill generator: turns a window and a colour into the full
// CASET/RASET/RAMWR + pixel word stream for the LCD SPI sender.
module lcd_fill_engine
  import lcd_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int X_OFF  = DEF_X_OFF,
  parameter int Y_OFF  = DEF_Y_OFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        x0,
  input  logic [7:0]        y0,
  input  logic [7:0]        x1,
  input  logic [7:0]        y1,
  input  logic [15:0]       colour,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  input  logic              out_ready,
  output lcd_state_t        state
);

  lcd_state_t        state_n;
  logic [7:0]        x0_q, y0_q, x1_q, y1_q;
  logic [15:0]       colour_q;
  logic [14:0]       pix_cnt, cnt_dec;
  logic [7:0]        win_w, win_h;
  logic [15:0]       col0, col1, row0, row1;
  logic              bad, accept, xfer, advance, last;
  logic              in_valid, in_ready;
  logic [WORD_W-1:0] in_data;

  assign bad = (x0 > x1) || (y0 > y1) || (32'(x1) >= WIDTH) || (32'(y1) >= HEIGHT);
  assign accept  = (state == S_IDLE) && start && !bad;
  assign xfer    = out_valid && out_ready;
  assign advance = (state == S_IDLE) ? accept : xfer;
  assign cnt_dec = pix_cnt - 15'd1;
  assign last    = (cnt_dec == 15'd0);
  assign busy    = (state != S_IDLE);

  assign win_w = x1 - x0 + 8'd1;
  assign win_h = y1 - y0 + 8'd1;
  assign col0  = 16'(x0_q) + 16'(X_OFF);
  assign col1  = 16'(x1_q) + 16'(X_OFF);
  assign row0  = 16'(y0_q) + 16'(Y_OFF);
  assign row1  = 16'(y1_q) + 16'(Y_OFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      x0_q     <= '0;
      y0_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      colour_q <= '0;
      pix_cnt  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= state_n;
      done  <= (state == S_PIX_LO) && xfer && last;
      err   <= (state == S_IDLE) && start && bad;
      if ((state == S_IDLE) && start) begin
        x0_q     <= x0;
        y0_q     <= y0;
        x1_q     <= x1;
        y1_q     <= y1;
        colour_q <= colour;
      end
      // Pixel count is multiplied once, straight from the request inputs.
      if (accept)
        pix_cnt <= 15'(16'(win_w) * 16'(win_h));
      else if ((state == S_PIX_LO) && xfer)
        pix_cnt <= cnt_dec;
    end
  end

  // The state names the word currently held in the output register, so the
  // word loaded on an advance is the one belonging to the next state.
  always_comb begin
    state_n = state;
    if (advance) begin
      case (state)
        S_IDLE:   state_n = S_CASET;
        S_CASET:  state_n = S_CP0;
        S_CP0:    state_n = S_CP1;
        S_CP1:    state_n = S_CP2;
        S_CP2:    state_n = S_CP3;
        S_CP3:    state_n = S_RASET;
        S_RASET:  state_n = S_RP0;
        S_RP0:    state_n = S_RP1;
        S_RP1:    state_n = S_RP2;
        S_RP2:    state_n = S_RP3;
        S_RP3:    state_n = S_RAMWR;
        S_RAMWR:  state_n = S_PIX_HI;
        S_PIX_HI: state_n = S_PIX_LO;
        S_PIX_LO: state_n = last ? S_IDLE : S_PIX_HI;
        default:  state_n = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_data = '0;
    case (state_n)
      S_CASET:  in_data = lcd_word(1'b0, CMD_CASET);
      S_CP0:    in_data = lcd_word(1'b1, col0[15:8]);
      S_CP1:    in_data = lcd_word(1'b1, col0[7:0]);
      S_CP2:    in_data = lcd_word(1'b1, col1[15:8]);
      S_CP3:    in_data = lcd_word(1'b1, col1[7:0]);
      S_RASET:  in_data = lcd_word(1'b0, CMD_RASET);
      S_RP0:    in_data = lcd_word(1'b1, row0[15:8]);
      S_RP1:    in_data = lcd_word(1'b1, row0[7:0]);
      S_RP2:    in_data = lcd_word(1'b1, row1[15:8]);
      S_RP3:    in_data = lcd_word(1'b1, row1[7:0]);
      S_RAMWR:  in_data = lcd_word(1'b0, CMD_RAMWR);
      S_PIX_HI: in_data = lcd_word(1'b1, colour_q[15:8]);
      S_PIX_LO: in_data = lcd_word(1'b1, colour_q[7:0]);
      default:  in_data = '0;
    endcase
  end

  assign in_valid = advance && (state_n != S_IDLE);

  lcd_stream_reg u_stream_reg (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

endmodule

// File: tb/tb_lcd_fill_engine.sv
// Bench for lcd_fill_engine: directed request table plus hand-written
// sequences for single pixel, full screen, mid-fill start and reset abort.
module tb_lcd_fill_engine;
  import lcd_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  x0, y0, x1, y1;
  logic [15:0] colour;
  logic        busy, done, err, out_valid, out_ready;
  logic [8:0]  out_data;
  lcd_state_t  state;

  int tests = 0;
  int fails = 0;
  logic [8:0] exp_q[$];

  typedef struct {
    logic [7:0]  x0, y0, x1, y1;
    logic [15:0] colour;
    bit          exp_err;
    int          ready_mode;
  } vec_t;

  vec_t vecs[7];

  lcd_fill_engine dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x0        (x0),
    .y0        (y0),
    .x1        (x1),
    .y1        (y1),
    .colour    (colour),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: condition not met at %0t", name, $time);
  endtask

  // Reference stream built from the command set: offsets 40/53, MSB first.
  task automatic push_fill(input int a, input int b, input int c, input int d, input int col);
    int cs, ce, rs, re, n;
    cs = a + 40; ce = c + 40; rs = b + 53; re = d + 53;
    n  = (c - a + 1) * (d - b + 1);
    exp_q.push_back(9'h02A);
    exp_q.push_back(9'(256 + cs / 256)); exp_q.push_back(9'(256 + cs % 256));
    exp_q.push_back(9'(256 + ce / 256)); exp_q.push_back(9'(256 + ce % 256));
    exp_q.push_back(9'h02B);
    exp_q.push_back(9'(256 + rs / 256)); exp_q.push_back(9'(256 + rs % 256));
    exp_q.push_back(9'(256 + re / 256)); exp_q.push_back(9'(256 + re % 256));
    exp_q.push_back(9'h02C);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(9'(256 + col / 256));
      exp_q.push_back(9'(256 + col % 256));
    end
  endtask

  task automatic run_fill(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic [7:0] d, input logic [15:0] col, input int mode,
                          input int inject_at);
    int cycles = 0;
    int err_seen = 0;
    bit held = 1'b0;
    logic [8:0] held_data = '0;
    @(negedge clk);
    x0 = a; y0 = b; x1 = c; y1 = d; colour = col; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("valid_after_start", 32'(out_valid), 32'd1);
    while (exp_q.size() > 0) begin
      if (cycles > 70000) begin
        flag_fail("timeout");
        exp_q.delete();
        break;
      end
      out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cycles == inject_at) begin
        x0 = 8'd100; y0 = 8'd50; x1 = 8'd120; y1 = 8'd60; colour = 16'h5555;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (err) err_seen++;
      if (!out_valid) begin
        flag_fail("early_end");
        exp_q.delete();
        break;
      end
      if (held) chk("hold_stable", 32'(out_data), 32'(held_data));
      if (out_ready) begin
        chk("word", 32'(out_data), 32'(exp_q.pop_front()));
        held = 1'b0;
      end else begin
        held = 1'b1;
        held_data = out_data;
      end
      cycles++;
      if (exp_q.size() > 0) @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
    if (err) err_seen++;
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("valid_at_done", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    if (inject_at >= 0) chk("no_err_midfill", 32'(err_seen), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; colour = '0;

    vecs[0] = '{8'd5, 8'd0, 8'd4,   8'd0,   16'h1111, 1'b1, 0};
    vecs[1] = '{8'd0, 8'd0, 8'd240, 8'd0,   16'h2222, 1'b1, 0};
    vecs[2] = '{8'd0, 8'd0, 8'd0,   8'd135, 16'h3333, 1'b1, 0};
    vecs[3] = '{8'd0, 8'd5, 8'd0,   8'd4,   16'h4444, 1'b1, 0};
    vecs[4] = '{8'd3, 8'd7, 8'd5,   8'd8,   16'h1234, 1'b0, 1};
    vecs[5] = '{8'd238, 8'd133, 8'd239, 8'd134, 16'hABCD, 1'b0, 0};
    vecs[6] = '{8'd10, 8'd20, 8'd10, 8'd20, 16'h0001, 1'b0, 1};

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_state", 32'(state), 32'(S_IDLE));
    rst = 1'b0;
    @(negedge clk);

    // Single pixel, literal expected stream.
    exp_q = '{9'h02A, 9'h100, 9'h128, 9'h100, 9'h128, 9'h02B, 9'h100, 9'h135,
              9'h100, 9'h135, 9'h02C, 9'h1F8, 9'h100};
    run_fill(8'd0, 8'd0, 8'd0, 8'd0, 16'hF800, 0, -1);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].exp_err) begin
        @(negedge clk);
        x0 = vecs[i].x0; y0 = vecs[i].y0; x1 = vecs[i].x1; y1 = vecs[i].y1;
        colour = vecs[i].colour; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", 32'(err), 32'd1);
        chk("err_busy", 32'(busy), 32'd0);
        chk("err_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("err_one_cycle", 32'(err), 32'd0);
        chk("err_valid_after", 32'(out_valid), 32'd0);
      end else begin
        push_fill(int'(vecs[i].x0), int'(vecs[i].y0), int'(vecs[i].x1), int'(vecs[i].y1),
                  int'(vecs[i].colour));
        run_fill(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, vecs[i].colour,
                 vecs[i].ready_mode, -1);
      end
    end

    // 3x2 window with ready held high: same stream as the random-ready run.
    push_fill(3, 7, 5, 8, 16'h1234);
    run_fill(8'd3, 8'd7, 8'd5, 8'd8, 16'h1234, 0, -1);

    // start pulsed mid-fill with other coordinates must be ignored.
    push_fill(2, 3, 4, 5, 16'hBEEF);
    run_fill(8'd2, 8'd3, 8'd4, 8'd5, 16'hBEEF, 0, 5);

    // Full screen, literal header then alternating pixel bytes.
    exp_q = '{9'h02A, 9'h100, 9'h128, 9'h101, 9'h117, 9'h02B, 9'h100, 9'h135,
              9'h100, 9'h1BB, 9'h02C};
    for (int i = 0; i < 32400; i++) begin
      exp_q.push_back(9'h107);
      exp_q.push_back(9'h1E0);
    end
    run_fill(8'd0, 8'd0, 8'd239, 8'd134, 16'h07E0, 0, -1);

    // Reset during the pixel phase with backpressure applied.
    @(negedge clk);
    x0 = 8'd0; y0 = 8'd0; x1 = 8'd9; y1 = 8'd9; colour = 16'hCAFE; start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    chk("abort_pre_valid", 32'(out_valid), 32'd1);
    chk("abort_pre_pixel", 32'(out_data[8]), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_state", 32'(state), 32'(S_IDLE));
    @(negedge clk);
    rst = 1'b0;
    push_fill(7, 9, 7, 9, 16'h00FF);
    run_fill(8'd7, 8'd9, 8'd7, 8'd9, 16'h00FF, 0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
